bch_error_correct: RTL and testbench

//  Sink-side partner of the Chien-search error locator: buffers the received data bits of each codeword,

---
 rtl/bch_error_correct_pkg.sv | 24 ++
 rtl/bch_pingpong_buf.sv | 49 ++++
 rtl/bch_error_correct.sv | 190 +++++++++++++++++++
 tb/tb_bch_error_correct.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bch_error_correct_pkg.sv
// rtl/bch_error_correct_pkg.sv - shared bank-state encoding and codeword geometry helpers
// Purpose: bank-state enum plus WORDS/RUNT derivation used by the correction
//          path and future stream blocks.
// Ports:   none (package).
package bch_error_correct_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // Beats per codeword: ceil(data_bits / bits).
  function automatic int calc_words(input int data_bits, input int bits);
    return (data_bits + bits - 1) / bits;
  endfunction

  // Live bits on the final beat; 0 means the final beat is fully live.
  function automatic int calc_runt(input int data_bits, input int bits);
    return data_bits % bits;
  endfunction

endpackage

// File: rtl/bch_pingpong_buf.sv
// rtl/bch_pingpong_buf.sv - two-bank codeword storage, one write port, one registered-address read port
// Purpose: holds two codewords of WORDS x BITS. Writes land on the clock edge;
//          the read bank/address are captured when rd_en_i is high and the
//          selected word is presented on rd_data_o for the following cycle.
// Ports:   clk_i, reset_i    clock, sync active-high reset (read address only)
//          wr_en_i/wr_bank_i/wr_addr_i/wr_data_i   write port
//          rd_en_i/rd_bank_i/rd_addr_i             read address capture
//          rd_data_o                               word at the captured address
module bch_pingpong_buf
  #(parameter int WORDS = 8,
    parameter int BITS  = 8,
    parameter int AW    = 3)
  (input  logic            clk_i,
   input  logic            reset_i,
   input  logic            wr_en_i,
   input  logic            wr_bank_i,
   input  logic [AW-1:0]   wr_addr_i,
   input  logic [BITS-1:0] wr_data_i,
   input  logic            rd_en_i,
   input  logic            rd_bank_i,
   input  logic [AW-1:0]   rd_addr_i,
   output logic [BITS-1:0] rd_data_o);

  localparam int DEPTH = 1 << AW;

  logic [BITS-1:0] mem0_q [DEPTH];
  logic [BITS-1:0] mem1_q [DEPTH];
  logic            rbank_q;
  logic [AW-1:0]   raddr_q;

  // Storage carries no reset; stale contents are never read before a fill.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !wr_bank_i) mem0_q[wr_addr_i] <= wr_data_i;
    if (wr_en_i &&  wr_bank_i) mem1_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rbank_q <= 1'b0;
      raddr_q <= '0;
    end else if (rd_en_i) begin
      rbank_q <= rd_bank_i;
      raddr_q <= rd_addr_i;
    end
  end

  assign rd_data_o = rbank_q ? mem1_q[raddr_q] : mem0_q[raddr_q];

endmodule

// File: rtl/bch_error_correct.sv
// rtl/bch_error_correct.sv - ping-pong buffered XOR correction of received data by the Chien err stream
// Purpose: fills one bank with a received codeword while the other is
//          drained against the error-location stream; emits corrected beats
//          one cycle after each err beat, plus the flipped-bit count.
// Ports:   clk, reset                     clock, sync active-high reset
//          in_valid/first/last/data, in_ready   received data stream
//          err_valid/first/last, err            error-location stream (no backpressure)
//          out_valid/first/last/data            corrected stream
//          err_count                            flipped bits, valid with out_last
//          err_underflow, err_framing           sticky error flags
module bch_error_correct
  import bch_error_correct_pkg::*;
  #(parameter int DATA_BITS = 60,
    parameter int BITS      = 8,
    localparam int CW       = $clog2(DATA_BITS + 1))
  (input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic            in_first,
   input  logic            in_last,
   input  logic [BITS-1:0] in_data,
   output logic            in_ready,
   input  logic            err_first,
   input  logic            err_last,
   input  logic            err_valid,
   input  logic [BITS-1:0] err,
   output logic            out_valid,
   output logic            out_first,
   output logic            out_last,
   output logic [BITS-1:0] out_data,
   output logic [CW-1:0]   err_count,
   output logic            err_underflow,
   output logic            err_framing);

  localparam int WORDS = calc_words(DATA_BITS, BITS);
  localparam int RUNT  = calc_runt(DATA_BITS, BITS);
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [AW-1:0]   LAST_IDX  = AW'(WORDS - 1);
  localparam logic [BITS-1:0] RUNT_MASK = BITS'((1 << RUNT) - 1);

  bank_state_e     st_q [2];
  bank_state_e     st_d [2];
  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   err_count_q, err_count_d;
  logic            out_valid_q, out_valid_d;
  logic            out_first_q, out_first_d;
  logic            out_last_q, out_last_d;
  logic [BITS-1:0] err_q, err_d;
  logic [BITS-1:0] mask_q, mask_d;
  logic            underflow_q, underflow_d;
  logic            framing_q, framing_d;

  logic            ready_w;
  logic            fill_live;
  logic [AW-1:0]   fill_idx;
  logic            rd_ok;
  logic            rd_acc;
  logic [AW-1:0]   rd_idx;
  logic [BITS-1:0] live_mask;
  logic [BITS-1:0] err_m;
  logic [CW-1:0]   pc;
  logic [CW-1:0]   cnt_sum;
  logic [BITS-1:0] rd_data;

  always_comb begin
    st_d        = st_q;
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    err_count_d = err_count_q;
    underflow_d = underflow_q;
    framing_d   = framing_q;

    // Fill side: a beat is live only when it opens a codeword or continues one.
    ready_w   = (st_q[wbank_q] == BANK_EMPTY) || (st_q[wbank_q] == BANK_FILLING);
    fill_live = in_valid && ready_w && (in_first || (st_q[wbank_q] == BANK_FILLING));
    fill_idx  = in_first ? '0 : wptr_q;

    if (fill_live) begin
      if ((fill_idx == LAST_IDX) && in_last) begin
        st_d[wbank_q] = BANK_FULL;
        wbank_d       = ~wbank_q;
        wptr_d        = '0;
      end else if ((fill_idx == LAST_IDX) || in_last) begin
        st_d[wbank_q] = BANK_EMPTY;
        wptr_d        = '0;
        framing_d     = 1'b1;
      end else begin
        st_d[wbank_q] = BANK_FILLING;
        wptr_d        = fill_idx + AW'(1);
      end
    end

    // Drain side: every err beat is consumed; only a loaded bank produces output.
    rd_ok     = (st_q[rbank_q] == BANK_FULL) || (st_q[rbank_q] == BANK_DRAINING);
    rd_acc    = err_valid && rd_ok;
    rd_idx    = err_first ? '0 : rptr_q;
    live_mask = ((RUNT != 0) && (rd_idx == LAST_IDX)) ? RUNT_MASK : '1;
    err_m     = err & live_mask;
    pc        = '0;
    for (int i = 0; i < BITS; i++) pc = pc + CW'(err_m[i]);
    cnt_sum   = (err_first ? '0 : cnt_q) + pc;

    if (err_valid && !rd_ok) underflow_d = 1'b1;

    if (rd_acc) begin
      st_d[rbank_q] = BANK_DRAINING;
      cnt_d         = cnt_sum;
      // Hold at the last word so an over-long err burst never reads out of range.
      rptr_d        = (rd_idx == LAST_IDX) ? rd_idx : rd_idx + AW'(1);
      if (err_last) begin
        st_d[rbank_q] = BANK_EMPTY;
        rbank_d       = ~rbank_q;
        rptr_d        = '0;
        err_count_d   = cnt_sum;
      end
    end

    out_valid_d = rd_acc;
    out_first_d = rd_acc && err_first;
    out_last_d  = rd_acc && err_last;
    err_d       = err_m;
    mask_d      = live_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q[0]     <= BANK_EMPTY;
      st_q[1]     <= BANK_EMPTY;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      err_count_q <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= '0;
      mask_q      <= '0;
      underflow_q <= 1'b0;
      framing_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      err_count_q <= err_count_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      mask_q      <= mask_d;
      underflow_q <= underflow_d;
      framing_q   <= framing_d;
    end
  end

  bch_pingpong_buf #(.WORDS(WORDS), .BITS(BITS), .AW(AW)) u_buf (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (fill_live),
    .wr_bank_i (wbank_q),
    .wr_addr_i (fill_idx),
    .wr_data_i (in_data),
    .rd_en_i   (rd_acc),
    .rd_bank_i (rbank_q),
    .rd_addr_i (rd_idx),
    .rd_data_o (rd_data)
  );

  // Read data arrives the cycle after the err beat, aligned with the registered err.
  assign out_data      = out_valid_q ? ((rd_data ^ err_q) & mask_q) : '0;
  assign in_ready      = (st_q[wbank_q] == BANK_EMPTY) || (st_q[wbank_q] == BANK_FILLING);
  assign out_valid     = out_valid_q;
  assign out_first     = out_first_q;
  assign out_last      = out_last_q;
  assign err_count     = err_count_q;
  assign err_underflow = underflow_q;
  assign err_framing   = framing_q;

endmodule

// File: tb/tb_bch_error_correct.sv
// tb/tb_bch_error_correct.sv - directed self-checking bench for bch_error_correct (DATA_BITS=60, BITS=8)
module tb_bch_error_correct;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_first, in_last;
  logic [7:0] in_data;
  logic       in_ready;
  logic       err_first, err_last, err_valid;
  logic [7:0] err;
  logic       out_valid, out_first, out_last;
  logic [7:0] out_data;
  logic [5:0] err_count;
  logic       err_underflow, err_framing;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] outs [8];

  always #5 clk = ~clk;

  bch_error_correct #(.DATA_BITS(60), .BITS(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready),
    .err_first(err_first), .err_last(err_last), .err_valid(err_valid), .err(err),
    .out_valid(out_valid), .out_first(out_first), .out_last(out_last), .out_data(out_data),
    .err_count(err_count), .err_underflow(err_underflow), .err_framing(err_framing)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cw(input logic [7:0] d, input int nbeats, input int last_at);
    for (int b = 0; b < nbeats; b++) begin
      in_valid = 1'b1;
      in_first = (b == 0);
      in_last  = (b == last_at);
      in_data  = d;
      tick();
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // Drains one 8-beat codeword; data beat 7 keeps only its 4 live bits.
  task automatic drain(input string tn, input logic [7:0] d, input int ebeat,
                       input logic [7:0] ev, input logic [5:0] ecnt, input bit stall_chk);
    logic [7:0] e, m;
    for (int b = 0; b < 8; b++) begin
      e         = (b == ebeat) ? ev : 8'h00;
      m         = (b == 7) ? 8'h0F : 8'hFF;
      err_valid = 1'b1;
      err_first = (b == 0);
      err_last  = (b == 7);
      err       = e;
      tick();
      outs[b] = out_data;
      check($sformatf("%s_valid%0d", tn, b), out_valid, 1'b1);
      check($sformatf("%s_data%0d", tn, b), out_data, (d ^ e) & m);
      if (b == 0) check($sformatf("%s_first", tn), out_first, 1'b1);
      if (b == 7) begin
        check($sformatf("%s_last", tn), out_last, 1'b1);
        check($sformatf("%s_count", tn), err_count, ecnt);
      end
      if (stall_chk) check($sformatf("%s_ready%0d", tn, b), in_ready, (b == 7));
    end
    err_valid = 1'b0;
    err_first = 1'b0;
    err_last  = 1'b0;
    err       = 8'h00;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = 8'h00;
    err_valid = 1'b0; err_first = 1'b0; err_last = 1'b0; err = 8'h00;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_err_count", err_count, 6'd0);
    check("rst_underflow", err_underflow, 1'b0);
    check("rst_framing", err_framing, 1'b0);
    reset = 1'b0;
    tick();

    // Single flipped bit on beat 3.
    send_cw(8'hA5, 8, 7);
    drain("a5", 8'hA5, 3, 8'h04, 6'd1, 1'b0);
    check("a5_beat3_hand", outs[3], 8'hA1);
    check("a5_beat0_hand", outs[0], 8'hA5);
    check("a5_beat7_runt", outs[7], 8'h05);
    tick();
    check("a5_idle_valid", out_valid, 1'b0);

    // Runt beat: only the 4 live bits may flip and be counted.
    send_cw(8'h3C, 8, 7);
    drain("runt", 8'h3C, 7, 8'hFF, 6'd4, 1'b0);
    check("runt_beat7_hand", outs[7], 8'h03);

    // Back-to-back fill with in_valid held high across both codewords.
    for (int b = 0; b < 16; b++) begin
      check($sformatf("b2b_ready%0d", b), in_ready, 1'b1);
      in_valid = 1'b1;
      in_first = (b % 8 == 0);
      in_last  = (b % 8 == 7);
      in_data  = (b < 8) ? 8'h11 : 8'h22;
      tick();
    end
    check("b2b_full_ready", in_ready, 1'b0);
    in_first = 1'b1; in_last = 1'b0; in_data = 8'h33;
    tick();
    check("b2b_stall_ready", in_ready, 1'b0);
    in_valid = 1'b0; in_first = 1'b0;
    drain("b2b1", 8'h11, 9, 8'h00, 6'd0, 1'b1);
    drain("b2b2", 8'h22, 0, 8'h80, 6'd1, 1'b0);
    check("b2b2_beat0_hand", outs[0], 8'hA2);

    // Misplaced in_last, then a clean codeword.
    send_cw(8'h77, 3, 2);
    check("frm_flag", err_framing, 1'b1);
    check("frm_ready", in_ready, 1'b1);
    check("frm_no_underflow", err_underflow, 1'b0);
    send_cw(8'h5A, 8, 7);
    drain("frm", 8'h5A, 5, 8'h01, 6'd1, 1'b0);
    check("frm_beat5_hand", outs[5], 8'h5B);

    // err beat with no loaded bank.
    err_valid = 1'b1; err_first = 1'b1; err_last = 1'b1; err = 8'hFF;
    tick();
    err_valid = 1'b0; err_first = 1'b0; err_last = 1'b0; err = 8'h00;
    check("unf_flag", err_underflow, 1'b1);
    check("unf_out_valid", out_valid, 1'b0);
    check("unf_count_held", err_count, 6'd1);

    // Reset in the middle of a drain.
    send_cw(8'hC3, 8, 7);
    for (int b = 0; b < 3; b++) begin
      err_valid = 1'b1; err_first = (b == 0); err = 8'h01;
      tick();
    end
    reset = 1'b1;
    tick();
    check("rmd_out_valid", out_valid, 1'b0);
    check("rmd_in_ready", in_ready, 1'b1);
    check("rmd_err_count", err_count, 6'd0);
    check("rmd_underflow", err_underflow, 1'b0);
    check("rmd_framing", err_framing, 1'b0);
    reset = 1'b0;
    err_valid = 1'b0; err_first = 1'b0; err = 8'h00;
    tick();
    err_valid = 1'b1; err_first = 1'b1;
    tick();
    err_valid = 1'b0; err_first = 1'b0;
    check("rmd_banks_empty", err_underflow, 1'b1);
    check("rmd_no_output", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
